// File: rtl/alu_issue.sv
// alu_issue: RV32I ALU-op decode and issue through a 2-entry skid buffer; optional FORWARDING_EN adds a writeback bypass
module alu_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs1_val,
    input  logic [31:0] in_rs2_val,
`ifdef FORWARDING_EN
    input  logic        fwd_valid,
    input  logic [4:0]  fwd_rd,
    input  logic [31:0] fwd_data,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [2:0]  out_op3,
    output logic [6:0]  out_op7,
    output logic [4:0]  out_rd,
    output logic        out_illegal
);
    typedef struct packed {
        logic        ill;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op3;
        logic [6:0]  op7;
        logic [4:0]  rd;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t      state, state_nx;
    entry_t      main_q, skid_q, dec;
    logic [31:0] r1, r2;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic        acc, drn, is_op, is_imm, sh, op_ok, imm_ok, legal;

`ifdef FORWARDING_EN
    assign r1 = fwd_valid && fwd_rd != 5'd0 && fwd_rd == in_instr[19:15] ? fwd_data : in_rs1_val;
    assign r2 = fwd_valid && fwd_rd != 5'd0 && fwd_rd == in_instr[24:20] ? fwd_data : in_rs2_val;
`else
    logic unused_rs1;
    assign unused_rs1 = ^in_instr[19:15];
    assign r1 = in_rs1_val;
    assign r2 = in_rs2_val;
`endif

    assign opc    = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];
    assign is_op  = opc == 7'b0110011;
    assign is_imm = opc == 7'b0010011;
    assign sh     = f3[1:0] == 2'b01;
    assign op_ok  = f7 == 7'd0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
    assign imm_ok = f3 == 3'b001 ? f7 == 7'd0 : f3 == 3'b101 ? (f7 == 7'd0 || f7 == 7'b0100000) : 1'b1;
    assign legal  = is_op ? op_ok : is_imm && imm_ok;
    assign acc    = in_valid && in_ready;
    assign drn    = out_valid && out_ready;
    assign out_valid = state != EMPTY;
    assign {out_illegal, out_a, out_b, out_op3, out_op7, out_rd} = main_q;

    // decode the incoming word into a buffer entry; illegal words carry only the flag
    always_comb begin
        dec     = '0;
        dec.ill = !legal;
        if (legal) begin
            dec.a   = r1;
            dec.b   = is_op ? r2 : sh ? {27'd0, in_instr[24:20]} : {{20{in_instr[31]}}, in_instr[31:20]};
            dec.op3 = f3;
            dec.op7 = is_op || sh ? f7 : 7'd0;
            dec.rd  = in_instr[11:7];
        end
    end

    // occupancy next-state from accept/drain handshakes
    always_comb begin
        state_nx = state == EMPTY ? (acc ? ONE : EMPTY)
                 : state == ONE   ? (acc && !drn ? FULL : !acc && drn ? EMPTY : ONE)
                 :                  (drn ? ONE : FULL);
    end

    // occupancy register; in_ready is registered from the next occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nx;
            in_ready <= state_nx != FULL;
        end
    end

    // main feeds the outputs; skid catches the word accepted while main is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (state == FULL) begin
            if (drn) main_q <= skid_q;
        end else if (acc && (state == EMPTY || drn)) begin
            main_q <= dec;
        end else if (acc) begin
            skid_q <= dec;
        end
    end
endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: in_valid  in  1  upstream instruction valid; in_ready  out  1  block can accept.
REQ-004 SHALL have: in_instr  in  32  RV32I instruction word; in_rs1_val, in_rs2_val  in  32 each  register-file read data.
REQ-005 SHALL have: out_valid  out  1; out_ready  in  1  ALU-side consumer ready.
REQ-006 SHALL have: out_a, out_b  out  32 each  ALU operands; out_op3  out  3; out_op7  out  7; out_rd  out  5; out_illegal  out  1.
REQ-007 SHALL have, only when FORWARDING_EN defined: fwd_valid  in  1; fwd_rd  in  5; fwd_data  in  32  writeback bypass.

Function
REQ-008 Transfer in SHALL occur when in_valid && in_ready; out SHALL occur when out_valid && out_ready.
REQ-009 Latency SHALL be 1 cycle: data accepted at edge N appears on out_* after edge N; sustained throughput 1/cycle with out_ready held high.
REQ-010 Storage SHALL be a 2-entry skid buffer (main + skid); states EMPTY, ONE, FULL.
REQ-011 EMPTY: accept -> ONE. ONE: accept only -> FULL if !out_ready, else stays ONE; drain only -> EMPTY; accept+drain -> ONE. FULL: drain -> ONE (skid moves to main); no accept in FULL.
REQ-012 in_ready SHALL be a registered signal, 1 in EMPTY/ONE, 0 in FULL; never combinationally dependent on out_ready.
REQ-013 out_* SHALL hold stable while out_valid && !out_ready; order of instructions SHALL be preserved.
REQ-014 Decode opcode 0110011 (OP): a=rs1_val, b=rs2_val, op3=funct3, op7=funct7.
REQ-015 Decode opcode 0010011 (OP-IMM): a=rs1_val; funct3 001/101: b={27'b0, instr[24:20]}, op7=funct7; else b=sign-extended instr[31:20], op7=0.
REQ-016 out_rd SHALL equal instr[11:7] for legal instructions.
REQ-017 Illegal SHALL be: any other opcode; OP with funct7 not 0000000/0100000; OP funct7 0100000 with funct3 not 000/101; OP-IMM funct3 001 with funct7!=0; OP-IMM funct3 101 with funct7 not 0000000/0100000.
REQ-018 Illegal instructions SHALL pass through the buffer with out_illegal=1, out_a=out_b=0, op3=0, op7=0, rd=0.
REQ-019 Decode and operand selection SHALL be applied at capture; buffered entries never re-sample inputs.

Reset
REQ-020 rst_n low SHALL immediately force state EMPTY, out_valid=0, in_ready=1, all out_* data fields 0.
REQ-021 Reset mid-operation SHALL discard both buffered entries; no transfer completes on the edge where rst_n rises.

Configuration
REQ-022 Macro FORWARDING_EN: defined -> at capture, if fwd_valid && fwd_rd!=0 && fwd_rd==instr[19:15], a=fwd_data; same for rs2 (OP only) with instr[24:20].
REQ-023 Both rs1 and rs2 SHALL forward simultaneously when both match.
REQ-024 Without FORWARDING_EN: fwd_* ports absent; operands always from in_rs1_val/in_rs2_val.

Verification
REQ-025 Reset then in_instr=0x003100B3 (add x1,x2,x3), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, a=5, b=7, op3=0, op7=0, rd=1.
REQ-026 addi x5,x6,-1 (0xFFF30293), rs1=0x10 -> b=0xFFFFFFFF, op3=0, op7=0, rd=5.
REQ-027 out_ready=0, three back-to-back valid instructions -> two accepted, in_ready=0 after second edge; release out_ready -> both emerge in order, third accepted after in_ready returns to 1.
REQ-028 in_instr=0x0000006F (jal) -> out_illegal=1, all data fields 0; srai with funct7=0100000 legal with op7=0100000, b=shamt.
REQ-029 FORWARDING_EN: fwd_valid=1, fwd_rd=2, fwd_data=0xAA, add x1,x2,x2 -> a=b=0xAA; fwd_rd=0 -> no bypass.
REQ-030 Assert rst_n=0 in FULL state mid-cycle -> out_valid drops immediately, in_ready=1, no stale output after release.
